quire_window_arbiter: RTL and testbench



---
 rtl/quire_window_arbiter_pkg.sv | 35 +++
 rtl/quire_window_arbiter_owner_fifo.sv | 80 ++++++++
 rtl/quire_window_arbiter.sv | 243 ++++++++++++++++++++++++
 tb/tb_quire_window_arbiter.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/quire_window_arbiter_pkg.sv
// Shared types and constants for the quire window arbiter.
//   QUIRE_4_0_W / P4_FRAC_W / P4_SCALE_W : field widths of the posit<4,0> datapath
//   arb_state_t : window arbiter FSM states
//   p4_prod_t   : one posit<4,0> product beat as seen by the quire
//   wrap_inc    : modulo-n increment used for the round-robin pointer
package quire_window_arbiter_pkg;

   localparam int QUIRE_4_0_W = 19;
   localparam int P4_FRAC_W   = 4;
   localparam int P4_SCALE_W  = 4;

   typedef enum logic [0:0] {
      ARB_IDLE   = 1'b0,
      ARB_LOCKED = 1'b1
   } arb_state_t;

   typedef struct packed {
      logic [P4_FRAC_W-1:0]         fraction;
      logic signed [P4_SCALE_W-1:0] scale;
      logic                         sign;
      logic                         zero;
      logic                         NaR;
   } p4_prod_t;

   function automatic int wrap_inc(input int v, input int n);
      int r;
      if (v + 32'sd1 >= n) begin
         r = 32'sd0;
      end else begin
         r = v + 32'sd1;
      end
      return r;
   endfunction

endpackage

// File: rtl/quire_window_arbiter_owner_fifo.sv
// window_owner_fifo: synchronous FIFO of requester ids, one entry per window
// whose eow beat has reached the quire but whose result is not yet returned.
//   clk, rst_n : clock, async active-low reset
//   push_i/data_i : write one id (ignored when full)
//   pop_i  : drop the head entry (ignored when empty)
//   data_o : head entry; empty_o/full_o/count_o : occupancy
module window_owner_fifo #(
   parameter int W     = 1,
   parameter int DEPTH = 4,
   parameter int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_i,
   input  logic [W-1:0]     data_i,
   input  logic             pop_i,
   output logic [W-1:0]     data_o,
   output logic             empty_o,
   output logic             full_o,
   output logic [CNT_W-1:0] count_o
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [W-1:0]     mem_q [DEPTH];
   logic [W-1:0]     mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             push_ok_s, pop_ok_s;

   // Occupancy flags and head entry.
   always_comb begin
      empty_o = (count_q == CNT_W'(0));
      full_o  = (count_q == CNT_W'(DEPTH));
      count_o = count_q;
      data_o  = mem_q[rd_ptr_q];
   end

   // Next pointer, storage and count; depth is a power of two so pointers wrap naturally.
   always_comb begin
      push_ok_s = push_i & ~full_o;
      pop_ok_s  = pop_i & ~empty_o;
      mem_d     = mem_q;
      if (push_ok_s) begin
         mem_d[wr_ptr_q] = data_i;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_ok_s) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({push_ok_s, pop_ok_s})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // FIFO state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= W'(0);
         end
         wr_ptr_q <= PTR_W'(0);
         rd_ptr_q <= PTR_W'(0);
         count_q  <= CNT_W'(0);
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/quire_window_arbiter.sv
// quire_window_arbiter: shares one quire_4_0 accumulator between NUM_REQ
// posit<4,0> product streams, one owner per window (sow..eow).
//   req_*   : per-requester product beats (packed fields, requester k at [k*4 +: 4])
//   q_*_o / q_rtr_i : beat path to the quire, a pure combinational mux of the owner
//   q_*_i / q_rtr_o : quire outputs; intermediate values are swallowed,
//                     eow results are tagged with the issuing requester
//   res_*   : tagged final results
//   proto_err_o : one-cycle pulse for any protocol violation seen that cycle
module quire_window_arbiter
   import quire_window_arbiter_pkg::*;
#(
   parameter int NUM_REQ          = 2,
   parameter int OWNER_FIFO_DEPTH = 4,
   parameter int ID_W             = $clog2(NUM_REQ)
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [NUM_REQ-1:0]          req_rts_i,
   output logic [NUM_REQ-1:0]          req_rtr_o,
   input  logic [NUM_REQ-1:0]          req_sow_i,
   input  logic [NUM_REQ-1:0]          req_eow_i,
   input  logic [4*NUM_REQ-1:0]        req_fraction_i,
   input  logic [4*NUM_REQ-1:0]        req_scale_i,
   input  logic [NUM_REQ-1:0]          req_sign_i,
   input  logic [NUM_REQ-1:0]          req_zero_i,
   input  logic [NUM_REQ-1:0]          req_NaR_i,
   output logic                        q_rts_o,
   output logic                        q_sow_o,
   output logic                        q_eow_o,
   output logic                        q_sign_o,
   output logic                        q_zero_o,
   output logic                        q_NaR_o,
   output logic [3:0]                  q_fraction_o,
   output logic [3:0]                  q_scale_o,
   input  logic                        q_rtr_i,
   input  logic                        q_rts_i,
   input  logic                        q_eow_i,
   input  logic                        q_sow_i,
   input  logic                        q_NaR_i,
   input  logic                        q_sign_i,
   input  logic                        q_zero_i,
   input  logic [QUIRE_4_0_W-1:0]      q_data_i,
   output logic                        q_rtr_o,
   output logic                        res_rts_o,
   input  logic                        res_rtr_i,
   output logic [ID_W-1:0]             res_id_o,
   output logic [QUIRE_4_0_W-1:0]      res_data_o,
   output logic                        res_NaR_o,
   output logic                        res_sign_o,
   output logic                        res_zero_o,
   output logic                        proto_err_o
);

   localparam int CNT_W = $clog2(OWNER_FIFO_DEPTH) + 1;

   arb_state_t       state_q, state_d;
   logic [ID_W-1:0]  owner_q, owner_d;
   logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
   // Set while the owner's first (sow) beat has not yet been accepted.
   logic             first_q, first_d;

   p4_prod_t         prod_s [NUM_REQ];
   p4_prod_t         owned_s;
   logic [NUM_REQ-1:0] cand_s;
   logic             pick_valid_s;
   logic [ID_W-1:0]  pick_id_s;
   logic [CNT_W:0]   reserved_s;
   logic             grant_room_s;
   logic             idle_err_s, sow_err_s, res_err_s;
   logic             beat_accept_s, beat_eow_s;
   logic             push_s, pop_s;
   logic [ID_W-1:0]  fifo_head_s;
   logic             fifo_empty_s, fifo_full_s;
   logic [CNT_W-1:0] fifo_count_s;
   logic             unused_s;

   assign unused_s = q_sow_i ^ fifo_full_s;

   // Unpack the per-requester product fields.
   always_comb begin
      for (int k = 0; k < NUM_REQ; k++) begin
         prod_s[k].fraction = req_fraction_i[k*P4_FRAC_W +: P4_FRAC_W];
         prod_s[k].scale    = req_scale_i[k*P4_SCALE_W +: P4_SCALE_W];
         prod_s[k].sign     = req_sign_i[k];
         prod_s[k].zero     = req_zero_i[k];
         prod_s[k].NaR      = req_NaR_i[k];
      end
   end

   // Round-robin pick among requesters offering a window start, plus window budget.
   always_comb begin
      cand_s       = req_rts_i & req_sow_i;
      pick_valid_s = 1'b0;
      pick_id_s    = ID_W'(0);
      for (int i = 0; i < NUM_REQ; i++) begin
         int idx;
         idx = (int'(rr_ptr_q) + i) % NUM_REQ;
         if (!pick_valid_s && cand_s[idx]) begin
            pick_valid_s = 1'b1;
            pick_id_s    = ID_W'(idx);
         end else begin
            pick_valid_s = pick_valid_s;
         end
      end
      // An active window counts against the budget until its eow is pushed.
      reserved_s   = {1'b0, fifo_count_s} + {{CNT_W{1'b0}}, (state_q == ARB_LOCKED)};
      grant_room_s = (reserved_s < (CNT_W+1)'(OWNER_FIFO_DEPTH));
      idle_err_s   = (state_q == ARB_IDLE) & (|(req_rts_i & ~req_sow_i));
   end

   // FSM next-state: grant in IDLE, release on the accepted eow beat.
   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      rr_ptr_d = rr_ptr_q;
      first_d  = first_q;
      push_s   = 1'b0;
      case (state_q)
         ARB_IDLE: begin
            if (pick_valid_s && grant_room_s) begin
               state_d = ARB_LOCKED;
               owner_d = pick_id_s;
               first_d = 1'b1;
            end else begin
               state_d = ARB_IDLE;
            end
         end
         ARB_LOCKED: begin
            if (beat_accept_s) begin
               first_d = 1'b0;
               if (beat_eow_s) begin
                  push_s   = 1'b1;
                  rr_ptr_d = ID_W'(wrap_inc(int'(owner_q), NUM_REQ));
                  state_d  = ARB_IDLE;
               end else begin
                  state_d = ARB_LOCKED;
               end
            end else begin
               state_d = ARB_LOCKED;
            end
         end
         default: begin
            state_d = ARB_IDLE;
         end
      endcase
   end

   // FSM outputs: beat path mux and per-requester ready.
   always_comb begin
      owned_s       = prod_s[owner_q];
      req_rtr_o     = {NUM_REQ{1'b0}};
      q_rts_o       = 1'b0;
      q_sow_o       = 1'b0;
      q_eow_o       = 1'b0;
      q_sign_o      = 1'b0;
      q_zero_o      = 1'b0;
      q_NaR_o       = 1'b0;
      q_fraction_o  = 4'h0;
      q_scale_o     = 4'h0;
      beat_accept_s = 1'b0;
      beat_eow_s    = 1'b0;
      sow_err_s     = 1'b0;
      if (state_q == ARB_LOCKED) begin
         q_rts_o            = req_rts_i[owner_q];
         q_sow_o            = req_sow_i[owner_q];
         q_eow_o            = req_eow_i[owner_q];
         q_sign_o           = owned_s.sign;
         q_zero_o           = owned_s.zero;
         q_NaR_o            = owned_s.NaR;
         q_fraction_o       = owned_s.fraction;
         q_scale_o          = owned_s.scale;
         req_rtr_o[owner_q] = q_rtr_i;
         beat_accept_s      = req_rts_i[owner_q] & q_rtr_i;
         beat_eow_s         = req_eow_i[owner_q];
         // sow is legal only on the beat that opened the window.
         sow_err_s          = beat_accept_s & req_sow_i[owner_q] & ~first_q;
      end else begin
         beat_accept_s = 1'b0;
      end
   end

   // Result side: swallow intermediate quire values, tag eow results with the fifo head.
   always_comb begin
      res_rts_o  = 1'b0;
      res_id_o   = ID_W'(0);
      res_data_o = QUIRE_4_0_W'(0);
      res_NaR_o  = 1'b0;
      res_sign_o = 1'b0;
      res_zero_o = 1'b0;
      q_rtr_o    = 1'b1;
      pop_s      = 1'b0;
      res_err_s  = 1'b0;
      if (q_rts_i && q_eow_i) begin
         if (!fifo_empty_s) begin
            res_rts_o  = 1'b1;
            res_id_o   = fifo_head_s;
            res_data_o = q_data_i;
            res_NaR_o  = q_NaR_i;
            res_sign_o = q_sign_i;
            res_zero_o = q_zero_i;
            q_rtr_o    = res_rtr_i;
            pop_s      = res_rtr_i;
         end else begin
            res_err_s = 1'b1;
         end
      end else begin
         q_rtr_o = 1'b1;
      end
      proto_err_o = idle_err_s | sow_err_s | res_err_s;
   end

   // FSM and arbitration state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ARB_IDLE;
         owner_q  <= ID_W'(0);
         rr_ptr_q <= ID_W'(0);
         first_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         rr_ptr_q <= rr_ptr_d;
         first_q  <= first_d;
      end
   end

   window_owner_fifo #(
      .W     (ID_W),
      .DEPTH (OWNER_FIFO_DEPTH),
      .CNT_W (CNT_W)
   ) u_owner_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push_s),
      .data_i  (owner_q),
      .pop_i   (pop_s),
      .data_o  (fifo_head_s),
      .empty_o (fifo_empty_s),
      .full_o  (fifo_full_s),
      .count_o (fifo_count_s)
   );

endmodule

// File: tb/tb_quire_window_arbiter.sv
`timescale 1ns/1ps
module tb_quire_window_arbiter;
   import quire_window_arbiter_pkg::*;

   localparam int N     = 2;
   localparam int DEPTH = 4;
   localparam int IDW   = 1;

   typedef struct packed {
      logic [N-1:0]  req_rtr;
      logic          q_rts, q_sow, q_eow, q_sign, q_zero, q_NaR;
      logic [3:0]    q_frac, q_scale;
      logic          q_rtr, res_rts;
      logic [IDW-1:0] res_id;
      logic [18:0]   res_data;
      logic          res_NaR, res_sign, res_zero, err;
   } out_t;

   typedef struct {
      logic [N-1:0] rts, sow, eow;
      logic         qrts, qeow;
      logic [N-1:0] x_rtr;
      logic         x_qrts, x_qsow, x_rres, x_id, x_qrtr, x_err;
   } vec_t;

   logic clk;
   logic rst_n;
   logic [N-1:0]   req_rts_i, req_rtr_o, req_sow_i, req_eow_i;
   logic [4*N-1:0] req_fraction_i, req_scale_i;
   logic [N-1:0]   req_sign_i, req_zero_i, req_NaR_i;
   logic q_rts_o, q_sow_o, q_eow_o, q_sign_o, q_zero_o, q_NaR_o;
   logic [3:0] q_fraction_o, q_scale_o;
   logic q_rtr_i, q_rts_i, q_eow_i, q_sow_i, q_NaR_i, q_sign_i, q_zero_i;
   logic [18:0] q_data_i;
   logic q_rtr_o, res_rts_o, res_rtr_i;
   logic [IDW-1:0] res_id_o;
   logic [18:0] res_data_o;
   logic res_NaR_o, res_sign_o, res_zero_o, proto_err_o;

   quire_window_arbiter #(.NUM_REQ(N), .OWNER_FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_rts_i(req_rts_i), .req_rtr_o(req_rtr_o), .req_sow_i(req_sow_i), .req_eow_i(req_eow_i),
      .req_fraction_i(req_fraction_i), .req_scale_i(req_scale_i),
      .req_sign_i(req_sign_i), .req_zero_i(req_zero_i), .req_NaR_i(req_NaR_i),
      .q_rts_o(q_rts_o), .q_sow_o(q_sow_o), .q_eow_o(q_eow_o), .q_sign_o(q_sign_o),
      .q_zero_o(q_zero_o), .q_NaR_o(q_NaR_o), .q_fraction_o(q_fraction_o), .q_scale_o(q_scale_o),
      .q_rtr_i(q_rtr_i), .q_rts_i(q_rts_i), .q_eow_i(q_eow_i), .q_sow_i(q_sow_i),
      .q_NaR_i(q_NaR_i), .q_sign_i(q_sign_i), .q_zero_i(q_zero_i), .q_data_i(q_data_i),
      .q_rtr_o(q_rtr_o), .res_rts_o(res_rts_o), .res_rtr_i(res_rtr_i), .res_id_o(res_id_o),
      .res_data_o(res_data_o), .res_NaR_o(res_NaR_o), .res_sign_o(res_sign_o),
      .res_zero_o(res_zero_o), .proto_err_o(proto_err_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks;
   int n_err;
   int n_pops;
   out_t last_a;

   // reference model: window owner, round-robin pointer and a queue of windows awaiting results
   bit m_locked;
   bit m_first;
   int m_owner;
   int m_rr;
   int m_fifo[$];
   int mv_grant;
   bit mv_acc, mv_push, mv_pop;

   task automatic model_reset();
      m_locked = 1'b0;
      m_first  = 1'b0;
      m_owner  = 0;
      m_rr     = 0;
      m_fifo.delete();
   endtask

   task automatic model_eval(output out_t e);
      e = '0;
      e.q_rtr  = 1'b1;
      mv_grant = -1;
      mv_acc   = 1'b0;
      mv_push  = 1'b0;
      mv_pop   = 1'b0;
      if (!m_locked) begin
         for (int i = 0; i < N; i++) begin
            int k;
            k = (m_rr + i) % N;
            if (mv_grant < 0 && req_rts_i[k] && req_sow_i[k]) mv_grant = k;
         end
         for (int k = 0; k < N; k++) begin
            if (req_rts_i[k] && !req_sow_i[k]) e.err = 1'b1;
         end
         if (m_fifo.size() >= DEPTH) mv_grant = -1;
      end else begin
         e.q_rts   = req_rts_i[m_owner];
         e.q_sow   = req_sow_i[m_owner];
         e.q_eow   = req_eow_i[m_owner];
         e.q_sign  = req_sign_i[m_owner];
         e.q_zero  = req_zero_i[m_owner];
         e.q_NaR   = req_NaR_i[m_owner];
         e.q_frac  = req_fraction_i[4*m_owner +: 4];
         e.q_scale = req_scale_i[4*m_owner +: 4];
         e.req_rtr[m_owner] = q_rtr_i;
         mv_acc  = req_rts_i[m_owner] && q_rtr_i;
         mv_push = mv_acc && req_eow_i[m_owner];
         if (mv_acc && req_sow_i[m_owner] && !m_first) e.err = 1'b1;
      end
      if (q_rts_i && q_eow_i) begin
         if (m_fifo.size() > 0) begin
            e.res_rts  = 1'b1;
            e.res_id   = IDW'(m_fifo[0]);
            e.res_data = q_data_i;
            e.res_NaR  = q_NaR_i;
            e.res_sign = q_sign_i;
            e.res_zero = q_zero_i;
            e.q_rtr    = res_rtr_i;
            mv_pop     = res_rtr_i;
         end else begin
            e.err = 1'b1;
         end
      end
   endtask

   task automatic model_advance();
      if (!rst_n) begin
         model_reset();
      end else begin
         if (mv_pop) m_fifo.delete(0);
         if (mv_push) m_fifo.push_back(m_owner);
         if (!m_locked) begin
            if (mv_grant >= 0) begin
               m_locked = 1'b1;
               m_owner  = mv_grant;
               m_first  = 1'b1;
            end
         end else if (mv_acc) begin
            m_first = 1'b0;
            if (req_eow_i[m_owner]) begin
               m_locked = 1'b0;
               m_rr     = (m_owner + 1) % N;
            end
         end
      end
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // inputs are already driven (posedge+1); sample at negedge, compare with model, advance
   task automatic step(input string tag);
      out_t e;
      out_t a;
      @(negedge clk);
      if (!rst_n) model_reset();
      model_eval(e);
      a = {req_rtr_o, q_rts_o, q_sow_o, q_eow_o, q_sign_o, q_zero_o, q_NaR_o,
           q_fraction_o, q_scale_o, q_rtr_o, res_rts_o, res_id_o, res_data_o,
           res_NaR_o, res_sign_o, res_zero_o, proto_err_o};
      last_a = a;
      if (a.res_rts && res_rtr_i) n_pops++;
      chk(tag, 64'(a), 64'(e));
      model_advance();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input logic [N-1:0] rts, input logic [N-1:0] sow, input logic [N-1:0] eow);
      req_rts_i = rts;
      req_sow_i = sow;
      req_eow_i = eow;
   endtask

   task automatic set_q(input logic rts, input logic eow);
      q_rts_i = rts;
      q_eow_i = eow;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tbl [9];
      out_t rst_exp;
      int   pops0;
      logic [3:0] drain_ids;

      n_checks = 0;
      n_err    = 0;
      n_pops   = 0;
      rst_n    = 1'b0;
      set_req(2'b00, 2'b00, 2'b00);
      req_fraction_i = 8'hA3;
      req_scale_i    = 8'hC5;
      req_sign_i     = 2'b01;
      req_zero_i     = 2'b10;
      req_NaR_i      = 2'b00;
      q_rtr_i   = 1'b1;
      set_q(1'b0, 1'b0);
      q_sow_i   = 1'b0;
      q_NaR_i   = 1'b0;
      q_sign_i  = 1'b1;
      q_zero_i  = 1'b0;
      q_data_i  = 19'h1234B;
      res_rtr_i = 1'b1;
      model_reset();
      repeat (2) @(posedge clk);
      #1;

      // reset state
      step("reset_hold");
      rst_exp = '0;
      rst_exp.q_rtr = 1'b1;
      chk("reset_outputs", 64'(last_a), 64'(rst_exp));
      rst_n = 1'b1;

      // contention, 1-beat window and protocol-error vectors
      //          rts    sow    eow    qrts  qeow   rtr    qrts  qsow  rres  id    qrtr  err
      tbl[0] = '{2'b11, 2'b11, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[1] = '{2'b11, 2'b11, 2'b00, 1'b0, 1'b0, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[2] = '{2'b11, 2'b10, 2'b01, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[3] = '{2'b10, 2'b10, 2'b00, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      tbl[4] = '{2'b10, 2'b10, 2'b10, 1'b0, 1'b0, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[5] = '{2'b00, 2'b00, 2'b00, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      tbl[6] = '{2'b00, 2'b00, 2'b00, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      tbl[7] = '{2'b10, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      tbl[8] = '{2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      for (int i = 0; i < 9; i++) begin
         set_req(tbl[i].rts, tbl[i].sow, tbl[i].eow);
         set_q(tbl[i].qrts, tbl[i].qeow);
         step($sformatf("vec%0d_model", i));
         chk($sformatf("vec%0d_req_rtr", i), 64'(last_a.req_rtr), 64'(tbl[i].x_rtr));
         chk($sformatf("vec%0d_q_rts", i),   64'(last_a.q_rts),   64'(tbl[i].x_qrts));
         chk($sformatf("vec%0d_q_sow", i),   64'(last_a.q_sow),   64'(tbl[i].x_qsow));
         chk($sformatf("vec%0d_res_rts", i), 64'(last_a.res_rts), 64'(tbl[i].x_rres));
         chk($sformatf("vec%0d_res_id", i),  64'(last_a.res_id),  64'(tbl[i].x_id));
         chk($sformatf("vec%0d_q_rtr", i),   64'(last_a.q_rtr),   64'(tbl[i].x_qrtr));
         chk($sformatf("vec%0d_err", i),     64'(last_a.err),     64'(tbl[i].x_err));
      end

      // 3-beat window for req0 with quire backpressure, then result backpressure
      pops0 = n_pops;
      set_req(2'b01, 2'b01, 2'b00);
      step("bp_arb");
      step("bp_beat1");
      chk("bp_beat1_sow", 64'(last_a.q_sow), 64'(1));
      set_req(2'b01, 2'b00, 2'b00);
      q_rtr_i = 1'b0;
      for (int i = 0; i < 5; i++) begin
         set_q(i == 2, 1'b0);
         step("bp_stall");
         chk("bp_stall_req_rtr", 64'(last_a.req_rtr), 64'(0));
         chk("bp_stall_q_rts", 64'(last_a.q_rts), 64'(1));
      end
      set_q(1'b0, 1'b0);
      q_rtr_i = 1'b1;
      step("bp_beat2");
      chk("bp_beat2_req_rtr", 64'(last_a.req_rtr), 64'(1));
      set_req(2'b01, 2'b00, 2'b01);
      step("bp_beat3");
      set_req(2'b00, 2'b00, 2'b00);
      set_q(1'b1, 1'b0);
      step("bp_quire_mid");
      chk("bp_mid_res_rts", 64'(last_a.res_rts), 64'(0));
      set_q(1'b1, 1'b1);
      q_data_i  = 19'h5A5A5;
      res_rtr_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step("bp_res_hold");
         chk("bp_hold_q_rtr", 64'(last_a.q_rtr), 64'(0));
         chk("bp_hold_res_rts", 64'(last_a.res_rts), 64'(1));
         chk("bp_hold_data", 64'(last_a.res_data), 64'(19'h5A5A5));
         chk("bp_hold_id", 64'(last_a.res_id), 64'(0));
      end
      res_rtr_i = 1'b1;
      step("bp_res_pop");
      set_q(1'b0, 1'b0);
      step("bp_idle");
      chk("bp_one_result", 64'(n_pops - pops0), 64'(1));

      // owner fifo full: four 1-beat windows with results blocked
      res_rtr_i = 1'b0;
      set_req(2'b11, 2'b11, 2'b11);
      for (int i = 0; i < 8; i++) step("full_fill");
      for (int i = 0; i < 3; i++) begin
         step("full_blocked");
         chk("full_no_grant", 64'(last_a.req_rtr), 64'(0));
      end
      set_q(1'b1, 1'b1);
      res_rtr_i = 1'b1;
      step("full_pop");
      chk("full_pop_id", 64'(last_a.res_id), 64'(1));
      set_q(1'b0, 1'b0);
      res_rtr_i = 1'b0;
      step("full_pop_p1");
      chk("full_p1_req_rtr", 64'(last_a.req_rtr), 64'(0));
      step("full_pop_p2");
      chk("full_p2_req_rtr", 64'(last_a.req_rtr), 64'(2'b10));
      set_req(2'b00, 2'b00, 2'b00);
      set_q(1'b1, 1'b1);
      res_rtr_i = 1'b1;
      drain_ids = 4'b1010;
      for (int i = 0; i < 4; i++) begin
         step("full_drain");
         chk("full_drain_id", 64'(last_a.res_id), 64'(drain_ids[i]));
      end
      set_q(1'b0, 1'b0);
      step("full_done");

      // reset in the middle of a req1 window
      set_req(2'b10, 2'b10, 2'b00);
      step("rst_arb");
      step("rst_beat1");
      set_req(2'b10, 2'b00, 2'b00);
      rst_n = 1'b0;
      step("rst_active");
      chk("rst_req_rtr", 64'(last_a.req_rtr), 64'(0));
      chk("rst_res_rts", 64'(last_a.res_rts), 64'(0));
      chk("rst_q_rtr", 64'(last_a.q_rtr), 64'(1));
      chk("rst_q_rts", 64'(last_a.q_rts), 64'(0));
      set_req(2'b00, 2'b00, 2'b00);
      step("rst_hold");
      rst_n = 1'b1;
      step("rst_release");
      set_req(2'b10, 2'b10, 2'b00);
      step("rst2_arb");
      step("rst2_beat1");
      set_req(2'b10, 2'b00, 2'b10);
      step("rst2_beat2");
      set_req(2'b00, 2'b00, 2'b00);
      set_q(1'b1, 1'b1);
      step("rst2_result");
      chk("rst2_res_rts", 64'(last_a.res_rts), 64'(1));
      chk("rst2_res_id", 64'(last_a.res_id), 64'(1));
      set_q(1'b0, 1'b0);
      step("rst2_idle");

      // randomized traffic against the model
      for (int c = 0; c < 3000; c++) begin
         req_rts_i      = N'($urandom);
         req_sow_i      = N'($urandom);
         req_eow_i      = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
         req_fraction_i = (4*N)'($urandom);
         req_scale_i    = (4*N)'($urandom);
         req_sign_i     = N'($urandom);
         req_zero_i     = N'($urandom);
         req_NaR_i      = N'($urandom);
         q_rtr_i        = ($urandom_range(0, 3) != 0);
         q_rts_i        = $urandom_range(0, 1) == 1;
         q_eow_i        = ($urandom_range(0, 2) == 0);
         q_sow_i        = $urandom_range(0, 1) == 1;
         q_NaR_i        = $urandom_range(0, 1) == 1;
         q_sign_i       = $urandom_range(0, 1) == 1;
         q_zero_i       = $urandom_range(0, 1) == 1;
         q_data_i       = 19'($urandom);
         res_rtr_i      = ($urandom_range(0, 2) != 0);
         step("random");
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
